// File: rtl/video_timing_pkg.sv
// Shared 12 MHz composite-sync timing constants, pulse-class and decoder state encodings.
package video_timing_pkg;

    localparam int unsigned SCANLINE_64     = 768;
    localparam int unsigned HALFSCANLINE_32 = 384;
    localparam int unsigned HSYNC_4_7       = 57;
    localparam int unsigned SHORTSYNC_2_35  = 29;
    localparam int unsigned BROADSYNC_27_3  = 327;

    localparam logic [1:0] ClsShort = 2'd0;
    localparam logic [1:0] ClsHsync = 2'd1;
    localparam logic [1:0] ClsBroad = 2'd2;

    localparam logic [1:0] StSearch = 2'd0;
    localparam logic [1:0] StVsync  = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    function automatic logic [1:0] classify_width(input logic [9:0] width,
                                                  input logic [9:0] short_max,
                                                  input logic [9:0] broad_min);
        if (width < short_max) begin
            return ClsShort;
        end else if (width < broad_min) begin
            return ClsHsync;
        end
        return ClsBroad;
    endfunction

endpackage

// File: rtl/sync_pulse_classifier.sv
// Synchronises composite sync, detects edges and classifies each low pulse by width.
// Define VIDEO_SYNC_DECODER_DEGLITCH_EN to insert a 3-sample majority filter.
module sync_pulse_classifier
    import video_timing_pkg::*;
#(
    parameter int unsigned SHORT_MAX_CYCLES = 43,
    parameter int unsigned BROAD_MIN_CYCLES = 192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_i,
    output logic       fall_o,
    output logic       class_valid_o,
    output logic [1:0] class_o
);

    localparam logic [9:0] ShortMax = 10'(SHORT_MAX_CYCLES);
    localparam logic [9:0] BroadMin = 10'(BROAD_MIN_CYCLES);

    logic [1:0] sync_q;
    logic       s;
    logic       s_d_q;
    logic       fall;
    logic       rise;
    logic [9:0] low_cnt_q;
    logic       fall_q;
    logic       class_valid_q;
    logic [1:0] class_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sync_i};
        end
    end

`ifdef VIDEO_SYNC_DECODER_DEGLITCH_EN
    logic [1:0] hist_q;
    logic       maj_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
            maj_q  <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
            maj_q  <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) |
                      (hist_q[0] & hist_q[1]);
        end
    end

    assign s = maj_q;
`else
    assign s = sync_q[1];
`endif

    assign fall = s_d_q & ~s;
    assign rise = ~s_d_q & s;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d_q         <= 1'b1;
            low_cnt_q     <= 10'd0;
            fall_q        <= 1'b0;
            class_valid_q <= 1'b0;
            class_q       <= ClsShort;
        end else begin
            s_d_q         <= s;
            fall_q        <= fall;
            class_valid_q <= rise;
            // The falling-edge sample is itself low, so the count restarts at one.
            if (fall) begin
                low_cnt_q <= 10'd1;
            end else if (!s && low_cnt_q != 10'h3ff) begin
                low_cnt_q <= low_cnt_q + 10'd1;
            end
            if (rise) begin
                class_q <= classify_width(low_cnt_q, ShortMax, BroadMin);
            end
        end
    end

    assign fall_o        = fall_q;
    assign class_valid_o = class_valid_q;
    assign class_o       = class_q;

endmodule

// File: rtl/video_sync_decoder.sv
// Composite-sync field/line decoder: FSM, horizontal counter, line counter and strobes.
// Define VIDEO_SYNC_DECODER_DEGLITCH_EN to enable the input majority filter.
module video_sync_decoder
    import video_timing_pkg::*;
#(
    parameter int unsigned SHORT_MAX_CYCLES = 43,
    parameter int unsigned BROAD_MIN_CYCLES = 192,
    parameter int unsigned LINE_MIN_CYCLES  = 704
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sync,
    output logic       o_line_start,
    output logic       o_vsync,
    output logic       o_locked,
    output logic [8:0] o_line,
    output logic [9:0] o_x
);

    localparam logic [9:0] LineMin = 10'(LINE_MIN_CYCLES);

    logic       fall;
    logic       class_valid;
    logic [1:0] pulse_class;

    logic [1:0] state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [8:0] line_q, line_d;
    logic       line_start_q, line_start_d;
    logic       vsync_q, vsync_d;
    logic       locked_q;
    logic       line_accept;

    sync_pulse_classifier #(
        .SHORT_MAX_CYCLES(SHORT_MAX_CYCLES),
        .BROAD_MIN_CYCLES(BROAD_MIN_CYCLES)
    ) u_cls (
        .clk          (clk),
        .rst          (rst),
        .sync_i       (i_sync),
        .fall_o       (fall),
        .class_valid_o(class_valid),
        .class_o      (pulse_class)
    );

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        line_start_d = 1'b0;
        vsync_d      = 1'b0;
        x_d          = (x_q == 10'h3ff) ? x_q : x_q + 10'd1;
        // Half-line equalising pulses arrive too early in the line and are ignored.
        line_accept  = fall && (state_q == StSearch || x_q >= LineMin);

        if (line_accept) begin
            x_d          = 10'd0;
            line_start_d = 1'b1;
            if (state_q != StSearch && line_q != 9'h1ff) begin
                line_d = line_q + 9'd1;
            end
        end

        if (class_valid) begin
            case (state_q)
                StSearch: begin
                    if (pulse_class == ClsBroad) begin
                        state_d = StVsync;
                        vsync_d = 1'b1;
                        line_d  = 9'd0;
                    end
                end
                StVsync: begin
                    if (pulse_class != ClsBroad) begin
                        state_d = StLocked;
                    end
                end
                StLocked: begin
                    if (pulse_class == ClsBroad) begin
                        state_d = StVsync;
                        vsync_d = 1'b1;
                        line_d  = 9'd0;
                    end
                end
                default: state_d = StSearch;
            endcase
        end

        // Losing sync for a full counter span drops back to acquisition.
        if (x_q == 10'd1022 && !line_accept) begin
            state_d = StSearch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StSearch;
            x_q          <= 10'd0;
            line_q       <= 9'd0;
            line_start_q <= 1'b0;
            vsync_q      <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            line_q       <= line_d;
            line_start_q <= line_start_d;
            vsync_q      <= vsync_d;
            locked_q     <= (state_d == StLocked);
        end
    end

    assign o_line_start = line_start_q;
    assign o_vsync      = vsync_q;
    assign o_locked     = locked_q;
    assign o_line       = line_q;
    assign o_x          = x_q;

endmodule
